// File: rtl/alu_seq.sv
// alu_seq: registered ALU with START/BUSY/DONE handshake and status flags.
// Single-cycle ops complete one cycle after START. Define ALU_SEQ_MUL_EN to
// build the iterative shift-add multiplier for opcode 111. Without it, 111
// completes in one cycle with ERROR set.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             DONE,
    output logic             BUSY,
    output logic             ZERO,
    output logic             CARRY,
    output logic             ERROR
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             error_q, error_d;
    logic             idle_c;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mul_acc_c;
`endif

    logic [WIDTH:0]          add_c;
    logic [WIDTH:0]          sub_c;
    logic [SHW-1:0]          shamt_c;
    logic signed [WIDTH-1:0] d1_signed_c;
    logic [WIDTH-1:0]        alu_res_c;
    logic                    alu_carry_c;

    // Single-cycle datapath: result and carry straight from the inputs
    always_comb begin
        add_c       = {1'b0, DATA1} + {1'b0, DATA2};
        sub_c       = {1'b0, DATA1} + {1'b0, ~DATA2} + (WIDTH+1)'(1);
        shamt_c     = DATA2[SHW-1:0];
        d1_signed_c = $signed(DATA1);
        alu_res_c   = DATA2;
        alu_carry_c = 1'b0;
        case (SELECT)
            OP_FWD: alu_res_c = DATA2;
            OP_ADD: begin
                alu_res_c   = add_c[WIDTH-1:0];
                alu_carry_c = add_c[WIDTH];
            end
            OP_AND: alu_res_c = DATA1 & DATA2;
            OP_OR:  alu_res_c = DATA1 | DATA2;
            OP_SUB: begin
                alu_res_c   = sub_c[WIDTH-1:0];
                alu_carry_c = sub_c[WIDTH];
            end
            OP_SLL: alu_res_c = DATA1 << shamt_c;
            OP_SRA: alu_res_c = $unsigned(d1_signed_c >>> shamt_c);
            default: alu_res_c = DATA2;
        endcase
    end

    // Next-state: accept in IDLE, step the multiplier, form completion outputs
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        busy_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mul_acc_c = acc_q + (mplier_q[0] ? mcand_q : '0);
        idle_c    = (state_q == S_IDLE);
`else
        idle_c    = 1'b1;
`endif

        if (idle_c && START) begin
            if (SELECT == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
                state_d  = S_MUL;
                busy_d   = 1'b1;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, DATA1};
                mplier_d = DATA2;
`else
                done_d   = 1'b1;
                error_d  = 1'b1;
`endif
            end else begin
                done_d   = 1'b1;
                result_d = alu_res_c;
                zero_d   = (alu_res_c == '0);
                carry_d  = alu_carry_c;
            end
        end

`ifdef ALU_SEQ_MUL_EN
        // One shift-add step per cycle; START is ignored while here
        if (state_q == S_MUL) begin
            acc_d    = mul_acc_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = mul_acc_c[WIDTH-1:0];
                zero_d   = (mul_acc_c[WIDTH-1:0] == '0);
                carry_d  = |mul_acc_c[2*WIDTH-1:WIDTH];
            end else begin
                busy_d   = 1'b1;
            end
        end
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            error_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            error_q  <= error_d;
`ifdef ALU_SEQ_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign ZERO   = zero_q;
    assign CARRY  = carry_q;
    assign ERROR  = error_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8); follows ALU_SEQ_MUL_EN.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       DONE;
    logic       BUSY;
    logic       ZERO;
    logic       CARRY;
    logic       ERROR;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tag_n    = 0;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       carry;
        logic       err;
        int         due;
        int         tag;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .ZERO   (ZERO),
        .CARRY  (CARRY),
        .ERROR  (ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int tg, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s tag=%0d actual=%0h expected=%0h (cycle %0d)", nm, tg, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every DONE; flag missing or unexpected completions
    always @(negedge CLK) begin
        exp_t e;
        if (RESET === 1'b0) begin
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", -1, 32'(DONE), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", e.tag, 32'(cyc), 32'(e.due));
                    chk("result",  e.tag, 32'(RESULT), 32'(e.res));
                    chk("zero",    e.tag, 32'(ZERO),   32'(e.zero));
                    chk("carry",   e.tag, 32'(CARRY),  32'(e.carry));
                    chk("error",   e.tag, 32'(ERROR),  32'(e.err));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_done", e.tag, 32'(DONE), 32'd1);
            end
            if (ERROR === 1'b1 && DONE !== 1'b1)
                chk("error_without_done", -1, 32'(ERROR), 32'd0);
        end
    end

    task automatic drive(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic z, input logic c, input logic e,
                         input int lat);
        exp_t x;
        drive(sel, a, b);
        x.res = r; x.zero = z; x.carry = c; x.err = e;
        x.due = cyc + lat;
        x.tag = tag_n;
        tag_n++;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            START = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_result"}, -1, 32'(RESULT), 32'd0);
        chk({nm, "_done"},   -1, 32'(DONE),   32'd0);
        chk({nm, "_busy"},   -1, 32'(BUSY),   32'd0);
        chk({nm, "_zero"},   -1, 32'(ZERO),   32'd0);
        chk({nm, "_carry"},  -1, 32'(CARRY),  32'd0);
        chk({nm, "_error"},  -1, 32'(ERROR),  32'd0);
    endtask

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = 3'b000;
        DATA1  = 8'h00;
        DATA2  = 8'h00;

        // Reset held for two edges, then released
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk_all_zero("reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("idle_no_done", i, 32'(DONE), 32'd0);
        end

        // Back-to-back single-cycle ops on 0x04 / 0x05
        issue(3'b000, 8'h04, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1);
        issue(3'b001, 8'h04, 8'h05, 8'h09, 1'b0, 1'b0, 1'b0, 1);
        issue(3'b010, 8'h04, 8'h05, 8'h04, 1'b0, 1'b0, 1'b0, 1);
        issue(3'b011, 8'h04, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1);
        issue(3'b100, 8'h04, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
        // Boundaries
        issue(3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        issue(3'b100, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        issue(3'b101, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1);
        issue(3'b110, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0, 1);
        idle(3);

`ifdef ALU_SEQ_MUL_EN
        // 0x0C * 0x0B: BUSY for 8 cycles, operands scrambled after acceptance
        issue(3'b111, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, 1'b0, 9);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            START = 1'b0;
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            chk("mul1_busy", i, 32'(BUSY), 32'd1);
        end
        @(negedge CLK);
        chk("mul1_busy_end", 8, 32'(BUSY), 32'd0);
        idle(1);

        // 0x10 * 0x10 with an ADD start pulsed mid-operation
        issue(3'b111, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 9);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            START  = (i == 3);
            SELECT = 3'b001;
            DATA1  = 8'h01;
            DATA2  = 8'h01;
            chk("mul2_busy", i, 32'(BUSY), 32'd1);
        end
        @(negedge CLK);
        START = 1'b0;
        chk("mul2_busy_end", 8, 32'(BUSY), 32'd0);
        idle(2);

        // Reset in the middle of a multiply aborts it
        drive(3'b111, 8'h0C, 8'h0B);
        idle(4);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk_all_zero("mul_abort");
        idle(12);
        issue(3'b001, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1);
        idle(3);
`else
        // Opcode 111 without the multiplier: ERROR pulse, flags and result held
        issue(3'b111, 8'h01, 8'h02, 8'hF0, 1'b0, 1'b0, 1'b1, 1);
        issue(3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        issue(3'b111, 8'h33, 8'h44, 8'h00, 1'b1, 1'b1, 1'b1, 1);
        issue(3'b000, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
        idle(3);
        chk("busy_tied", -1, 32'(BUSY), 32'd0);

        // Reset after a nonzero result clears everything
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk_all_zero("reset2");
        idle(3);
`endif

        chk("scoreboard_empty", -1, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's single-cycle 8-bit ALU.
- Adds SUB, shifts, status flags, a START/BUSY/DONE handshake and an optional iterative multiplier.
- Sits between the register file outputs and the write-back mux.
- The control unit issues one operation at a time and waits for DONE before using RESULT.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), number of low DATA2 bits used as the shift amount (derived; not overridden).

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  3  opcode; captured with START.
- DATA1  input  WIDTH  operand A; captured with START.
- DATA2  input  WIDTH  operand B or shift amount; captured with START.
- RESULT  output  WIDTH  registered result; holds until the next completion.
- DONE  output  1  one-cycle pulse; RESULT and flags valid in the same cycle.
- BUSY  output  1  high while a multi-cycle operation runs.
- ZERO  output  1  RESULT == 0, updated at completion.
- CARRY  output  1  carry out of ADD/SUB; 0 for other ops.
- ERROR  output  1  pulses with DONE for an unsupported opcode.

Behaviour:
- Reset (RESET high at a rising edge):
  - RESULT=0, DONE=0, BUSY=0, ZERO=0, CARRY=0, ERROR=0.
  - FSM returns to IDLE and the multiply counter clears.
- Reset mid-operation aborts the operation; no DONE is produced for it.
- Opcodes:
  - 000 FWD: RESULT=DATA2.
  - 001 ADD: RESULT=DATA1+DATA2.
  - 010 AND.
  - 011 OR.
  - 100 SUB: RESULT=DATA1+~DATA2+1.
  - 101 SLL: DATA1 << DATA2[SHW-1:0].
  - 110 SRA: arithmetic right shift of DATA1 by DATA2[SHW-1:0].
  - 111 MUL: see the optional feature.
- Arithmetic rules:
  - Results wrap modulo 2^WIDTH.
  - CARRY is bit WIDTH of the WIDTH+1-bit sum. For SUB, CARRY=1 means no borrow (DATA1 >= DATA2 unsigned).
- FSM states: IDLE, MUL.
- IDLE:
  - START=1 with SELECT != 111: the result is computed combinationally from the inputs and registered at that edge. DONE=1 in the following cycle (latency 1) and the FSM stays in IDLE.
  - Back-to-back STARTs on consecutive cycles are allowed. DONE stays high across consecutive completions.
- MUL:
  - Entered from IDLE on START with SELECT=111 (macro defined).
  - Operands are latched and BUSY=1 from the next cycle.
  - One shift-add step per cycle; WIDTH steps in total.
  - On the last step the FSM writes the low WIDTH bits of the product to RESULT, pulses DONE, clears BUSY and returns to IDLE.
  - DONE appears WIDTH cycles after the accepting edge.
- START while BUSY=1 is ignored. It is not queued and does not disturb the operation in flight.
- Operand changes after acceptance have no effect on the operation in flight.
- DONE=0 in every cycle that has no completion. ERROR=0 unless stated otherwise.
- RESULT, ZERO and CARRY change only on completion cycles.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - Opcode 111 runs the iterative unsigned multiply described above.
  - CARRY=1 if the high WIDTH bits of the full product are nonzero (overflow); otherwise 0.
- Undefined:
  - No multiplier logic and no MUL state; BUSY is tied to 0.
  - Opcode 111 completes in 1 cycle with DONE=1, ERROR=1, RESULT unchanged, ZERO and CARRY unchanged.

Test Plan:
- Reset: hold RESET 2 cycles, then release -> all outputs 0; START=0 for 5 cycles -> DONE stays 0.
- Single-cycle ops (WIDTH=8), DATA1=0x04, DATA2=0x05, back-to-back START on consecutive cycles:
  - FWD -> 0x05.
  - ADD -> 0x09, CARRY 0.
  - AND -> 0x04.
  - OR -> 0x05.
  - SUB -> 0xFF, CARRY 0.
  - Each result appears with a DONE pulse 1 cycle after its START.
- Boundaries:
  - ADD 0xFF+0x01 -> RESULT 0x00, ZERO 1, CARRY 1.
  - SUB 0x05-0x05 -> 0x00, ZERO 1, CARRY 1.
  - SLL 0x81 by 0x09 (amount 1) -> 0x02.
  - SRA 0x80 by 3 -> 0xF0.
- MUL (macro on):
  - 0x0C*0x0B -> BUSY high for 8 cycles, DONE at cycle 8, RESULT 0x84, CARRY 0.
  - 0x10*0x10 -> RESULT 0x00, ZERO 1, CARRY 1.
  - START pulsed mid-MUL -> ignored; the original result is unchanged.
- RESET asserted at step 4 of a MUL -> the next cycle shows BUSY 0 and RESULT 0; no DONE follows.
- Macro off: SELECT=111 -> DONE and ERROR pulse 1 cycle after START; RESULT keeps its prior value.
